// File: rtl/pc_sequencer_if.sv
// Bus between the next-PC / decode logic (master) and the PC register stage (slave).
interface pc_sequencer_if;
    logic [31:0] NextPC;
    logic        PCWrite;
    logic        Halt;
    logic        Resume;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        Halted;
    logic        AlignFault;

    modport master (
        output NextPC, PCWrite, Halt, Resume,
        input  PC, PCPlus4, FetchValid, Halted, AlignFault
    );

    modport slave (
        input  NextPC, PCWrite, Halt, Resume,
        output PC, PCPlus4, FetchValid, Halted, AlignFault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register stage with a BOOT/RUN/HALT sequencer.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned jumps into a sticky fault plus halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic            CLK,
    input  logic            Reset,
    pc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        BOOT    = 2'b00,
        RUN     = 2'b01,
        HALT    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;

`ifdef PC_ALIGN_CHECK_EN
    logic        fault_q;
    logic        misaligned;
    assign misaligned = (bus.NextPC[1:0] != 2'b00);
`else
    logic        unused_low_bits;
    assign unused_low_bits = ^bus.NextPC[1:0];
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // Halt freezes PC on the halt instruction itself.
                    if (bus.Halt) begin
                        state_q <= HALT;
                    end else if (bus.PCWrite) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q <= bus.NextPC;
                        end
`else
                        pc_q <= {bus.NextPC[31:2], 2'b00};
`endif
                    end
                end
                HALT: begin
                    // Resuming skips past the instruction that halted.
                    if (bus.Resume) begin
                        state_q <= RUN;
                        pc_q    <= pc_q + PC_STEP;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_q + PC_STEP;
    assign bus.FetchValid = (state_q == RUN);
    assign bus.Halted     = (state_q == HALT);
`ifdef PC_ALIGN_CHECK_EN
    assign bus.AlignFault = fault_q;
`else
    assign bus.AlignFault = 1'b0;
`endif
endmodule
